// File: rtl/kt_pkg.sv
// Shared definitions for the kitchen timer: FSM state encoding and BCD digit limits.
package kt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } kt_state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/kt_bcd_digit.sv
// One BCD digit with increment/decrement, programmable wrap limit, and carry/borrow out.
module kt_bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    input  logic [3:0] max,
    output logic [3:0] digit,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc & (digit == max);
    assign borrow = dec & (digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            digit <= borrow ? max : digit - 4'd1;
        end
    end

endmodule

// File: rtl/kitchen_timer.sv
// Countdown kitchen timer with MM:SS BCD preset, 1 s prescaler and alarm.
// Define KT_BEEP_EN for a gated square-wave beep; otherwise beep mirrors alarm.
module kitchen_timer
    import kt_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int ALARM_SEC = 10,
    parameter int BEEP_DIV  = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       min_inc,
    input  logic       sec_inc,
    input  logic       clear,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       alarm,
    output logic       beep
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SEC - 1);

    if (TICK_DIV < 2 || ALARM_SEC < 1 || ALARM_SEC > 255 || BEEP_DIV < 1) begin : g_param_check
        $error("kitchen_timer: parameter out of range");
    end

    kt_state_t     state, state_n;
    logic [3:0]    btn_q, btn_prev, ev;
    logic          w_clr, w_ss, w_min, w_sec, any_ev;
    logic [CW-1:0] cnt;
    logic [7:0]    acnt;
    logic          tick, setting, time_zero, time_one;
    logic          inc_sec, inc_min, dec_time;
    logic          su_carry, su_borrow, st_borrow, mu_carry, mu_borrow;
    logic          st_carry_unused, mt_carry_unused, mt_borrow_unused;

    // Buttons packed as {clear, start_stop, min_inc, sec_inc}; registered once, then edge-detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q    <= '0;
            btn_prev <= '0;
        end else begin
            btn_q    <= {clear, start_stop, min_inc, sec_inc};
            btn_prev <= btn_q;
        end
    end

    assign ev     = btn_q & ~btn_prev;
    assign any_ev = |ev;
    assign w_clr  = ev[3];
    assign w_ss   = ev[2] & ~ev[3];
    assign w_min  = ev[1] & ~ev[2] & ~ev[3];
    assign w_sec  = ev[0] & ~ev[1] & ~ev[2] & ~ev[3];

    assign tick      = (state == RUN || state == ALARM) && (cnt == TICK_LAST);
    assign setting   = (state == IDLE) || (state == PAUSE);
    assign time_zero = ({min, sec} == 16'h0000);
    assign time_one  = ({min, sec} == 16'h0001);
    assign inc_sec   = setting & w_sec;
    assign inc_min   = setting & w_min;
    // A clear or start_stop in the same cycle as a tick wins; the tick is dropped.
    assign dec_time  = (state == RUN) & tick & ~w_clr & ~w_ss;

    kt_bcd_digit u_sec_units (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(inc_sec), .dec(dec_time),
        .max(DIGIT_MAX), .digit(sec[3:0]), .carry(su_carry), .borrow(su_borrow)
    );

    kt_bcd_digit u_sec_tens (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(su_carry), .dec(su_borrow),
        .max(SEC_TENS_MAX), .digit(sec[7:4]), .carry(st_carry_unused), .borrow(st_borrow)
    );

    kt_bcd_digit u_min_units (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(inc_min), .dec(st_borrow),
        .max(DIGIT_MAX), .digit(min[3:0]), .carry(mu_carry), .borrow(mu_borrow)
    );

    kt_bcd_digit u_min_tens (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(mu_carry), .dec(mu_borrow),
        .max(DIGIT_MAX), .digit(min[7:4]), .carry(mt_carry_unused), .borrow(mt_borrow_unused)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (w_ss && !time_zero) state_n = RUN;
            RUN: begin
                if (w_clr)                  state_n = IDLE;
                else if (w_ss)              state_n = PAUSE;
                else if (tick && time_one)  state_n = ALARM;
            end
            PAUSE: begin
                if (w_clr)                    state_n = IDLE;
                else if (w_ss && !time_zero)  state_n = RUN;
            end
            ALARM: begin
                if (any_ev)                             state_n = IDLE;
                else if (tick && acnt == ALARM_LAST)    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
            cnt     <= '0;
            acnt    <= '0;
        end else begin
            state   <= state_n;
            running <= (state_n == RUN);
            alarm   <= (state_n == ALARM);

            if (state_n != state && (state_n == RUN || state_n == ALARM))
                cnt <= '0;
            else if (state == RUN || state == ALARM)
                cnt <= tick ? '0 : cnt + 1'b1;

            if (state_n == ALARM && state != ALARM)
                acnt <= '0;
            else if (state == ALARM && tick)
                acnt <= acnt + 8'd1;
        end
    end

`ifdef KT_BEEP_EN
    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    logic [BW-1:0] bcnt;
    logic          tone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt <= '0;
            tone <= 1'b0;
        end else if (!alarm) begin
            bcnt <= '0;
            tone <= 1'b0;
        end else if (bcnt == BW'(BEEP_DIV - 1)) begin
            bcnt <= '0;
            tone <= ~tone;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // The tone is gated by the first half of each alarm second.
    assign beep = alarm & tone & (cnt < CW'(TICK_DIV / 2));
`else
    assign beep = alarm;
`endif

endmodule

// File: tb/tb_kitchen_timer.sv
// Self-checking bench for kitchen_timer: directed scenarios plus random button traffic
// compared every cycle against a seconds-based behavioural model.
module tb_kitchen_timer;

    localparam int TD = 4;
    localparam int AS = 3;
    localparam int BD = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop, min_inc, sec_inc, clear;
    logic [7:0] min, sec;
    logic       running, alarm, beep;

    always #5 clk = ~clk;

    kitchen_timer #(
        .TICK_DIV(TD),
        .ALARM_SEC(AS),
        .BEEP_DIV(BD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_stop(start_stop),
        .min_inc(min_inc),
        .sec_inc(sec_inc),
        .clear(clear),
        .min(min),
        .sec(sec),
        .running(running),
        .alarm(alarm),
        .beep(beep)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time kept as plain minutes/seconds, events derived from level history.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_t;
    mode_t    mode;
    int       mm, ss, pre, at;
    bit [3:0] lvl_d1, lvl_d2;
    bit       saw_beep_hi, saw_beep_lo;

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        mode = M_IDLE;
        mm = 0; ss = 0; pre = 0; at = 0;
        lvl_d1 = '0; lvl_d2 = '0;
    endtask

    task automatic model_step();
        bit [3:0] e;
        bit       tk;
        int       t;
        e = lvl_d1 & ~lvl_d2;
        lvl_d2 = lvl_d1;
        lvl_d1 = {clear, start_stop, min_inc, sec_inc};
        tk = (mode == M_RUN || mode == M_ALARM) && pre == TD - 1;
        t = mm * 60 + ss;
        case (mode)
            M_IDLE, M_PAUSE: begin
                if (e[3]) begin mm = 0; ss = 0; mode = M_IDLE; end
                else if (e[2]) begin
                    if (t != 0) begin mode = M_RUN; pre = 0; end
                end
                else if (e[1]) mm = (mm + 1) % 100;
                else if (e[0]) ss = (ss + 1) % 60;
            end
            M_RUN: begin
                if (e[3]) begin mm = 0; ss = 0; mode = M_IDLE; end
                else if (e[2]) mode = M_PAUSE;
                else if (tk) begin
                    t = t - 1;
                    mm = t / 60;
                    ss = t % 60;
                    pre = 0;
                    if (t == 0) begin mode = M_ALARM; at = 0; end
                end
                else pre++;
            end
            M_ALARM: begin
                if (e != 0) mode = M_IDLE;
                else if (tk) begin
                    at++;
                    pre = 0;
                    if (at == AS) mode = M_IDLE;
                end
                else pre++;
            end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("min", min, bcd(mm));
        check("sec", sec, bcd(ss));
        check("running", running, mode == M_RUN);
        check("alarm", alarm, mode == M_ALARM);
`ifdef KT_BEEP_EN
        if (mode != M_ALARM) check("beep_idle", beep, 0);
        else if (beep) saw_beep_hi = 1;
        else saw_beep_lo = 1;
`else
        check("beep", beep, mode == M_ALARM);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // mask = {clear, start_stop, min_inc, sec_inc}; high one cycle, low one cycle.
    task automatic press(input bit [3:0] mask);
        {clear, start_stop, min_inc, sec_inc} = mask;
        step();
        {clear, start_stop, min_inc, sec_inc} = 4'b0000;
        step();
    endtask

    task automatic preset(input int m, input int s);
        press(4'b1000);
        repeat (m) press(4'b0010);
        repeat (s) press(4'b0001);
    endtask

    initial begin
        int r;
        saw_beep_hi = 0;
        saw_beep_lo = 0;
        reset = 1'b1;
        {clear, start_stop, min_inc, sec_inc} = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_time", {min, sec}, 16'h0000);
        check("rst_flags", {running, alarm, beep}, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        // sec wraps 59 -> 00 without touching minutes
        repeat (61) press(4'b0001);
        check("wrap_sec", sec, 8'h01);
        check("wrap_min", min, 8'h00);

        // 01:00 countdown to alarm, then alarm timeout
        preset(1, 0);
        press(4'b0100);
        check("run_rise", running, 1);
        wait_cycles(4);
        check("t_0059", {min, sec}, 16'h0059);
        wait_cycles(236);
        check("alarm_on", alarm, 1);
        check("alarm_run", running, 0);
        check("alarm_time", {min, sec}, 16'h0000);
        wait_cycles(12);
        check("alarm_expire", alarm, 0);

        // pause at 00:01, hold, resume
        preset(0, 2);
        press(4'b0100);
        wait_cycles(4);
        check("t_0001", {min, sec}, 16'h0001);
        press(4'b0100);
        check("pause_run", running, 0);
        wait_cycles(20);
        check("pause_hold", {min, sec}, 16'h0001);
        press(4'b0100);
        wait_cycles(4);
        check("resume_alarm", alarm, 1);
        check("resume_time", {min, sec}, 16'h0000);

        // button event cancels alarm; start at 00:00 ignored
        press(4'b0010);
        check("cancel_alarm", alarm, 0);
        check("cancel_min", min, 8'h00);
        press(4'b0100);
        check("start_zero", running, 0);

        // clear + min_inc together during RUN
        preset(5, 30);
        press(4'b0100);
        check("t_0530", {min, sec}, 16'h0530);
        press(4'b1010);
        check("clr_run", running, 0);
        check("clr_time", {min, sec}, 16'h0000);

        // async reset mid-RUN, with a button held through release
        preset(3, 17);
        press(4'b0100);
        check("t_0317", {min, sec}, 16'h0317);
        #2;
        reset = 1'b1;
        #1;
        check("arst_time", {min, sec}, 16'h0000);
        check("arst_flags", {running, alarm, beep}, 3'b000);
        model_reset();
        min_inc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(3);
        check("held_after_rst", min, 8'h01);
        min_inc = 1'b0;
        step();

        // random single-button traffic
        press(4'b1000);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 5)       press(4'b0001);
            else if (r == 6)  press(4'b0010);
            else if (r <= 9)  press(4'b0100);
            else if (r == 10) press(4'b1000);
            else              wait_cycles($urandom_range(1, 12));
        end
        wait_cycles(40);

`ifdef KT_BEEP_EN
        check("beep_hi_seen", saw_beep_hi, 1);
        check("beep_lo_seen", saw_beep_lo, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
